// File: rtl/spi_dsp_bus_regs_pkg.sv
//==============================================================================
// Package : spi_regs_pkg - register map, CTRL/STATUS bit positions, enable FSM
// Rev     : 1.0
//==============================================================================
`default_nettype none

package spi_regs_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_POL_BIT = 3;
  localparam int unsigned CTRL_PHA_BIT = 4;
  localparam int unsigned CTRL_DIR_BIT = 5;
  localparam int unsigned CTRL_EN_BIT  = 6;
  localparam int unsigned CTRL_CLR_BIT = 7;
  localparam int unsigned CTRL_IRQ_BIT = 8;

  localparam int unsigned STATUS_RX_AVAIL_BIT = 7;
  localparam int unsigned STATUS_STATE_LSB    = 8;

  typedef enum logic [1:0] {
    EN_OFF   = 2'b00,
    EN_ON    = 2'b01,
    EN_DRAIN = 2'b10
  } en_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_dsp_bus_regs_strobe_sync.sv
//==============================================================================
// Module : spi_strobe_sync - SYNC_STAGES-deep synchroniser with edge pulses
// Rev    : 1.0
//==============================================================================
`default_nettype none

module spi_strobe_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic resetf,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Resetting to the idle level keeps a reset release from looking like an edge
  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];
  assign rise     = sync_out & ~r_prev;
  assign fall     = ~sync_out & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_dsp_bus_regs.sv
//==============================================================================
// Module : spi_dsp_bus_regs - DSP bus register front end for the SPI master top
//          Optional interrupt output enabled by SPI_DSP_BUS_IRQ_EN
// Rev    : 1.0
//==============================================================================
`default_nettype none

module spi_dsp_bus_regs
  import spi_regs_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CLEAN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetf,
  input  logic        cpu_cs_n,
  input  logic        cpu_we_n,
  input  logic        cpu_rd_n,
  input  logic [1:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        tx_str,
  output logic        rx_str,
  output logic [15:0] dataIn,
  output logic [2:0]  sclk_freq_divide,
  output logic        sclk_polarity,
  output logic        sdata_phase,
  output logic        data_tx_direction,
  output logic        spi_enable,
  output logic        fifo_cleaning,
  input  logic [15:0] dataOut,
  input  logic        read_valid,
  input  logic        tx_error,
  input  logic        tx_empty_flag,
  input  logic        tx_full_flag,
  input  logic        rx_error,
  input  logic        rx_empty_flag,
  input  logic        rx_full_flag,
  input  logic        master_busy
`ifdef SPI_DSP_BUS_IRQ_EN
  ,
  output logic        cpu_irq_n
`endif
);

  logic w_cs_sync, w_we_fall, w_rd_fall, w_rd_rise;
  logic w_unused_cs_rise, w_unused_cs_fall, w_unused_we_sync, w_unused_we_rise, w_unused_rd_sync;
  logic w_unused_wdata;

  spi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .resetf(resetf), .async_in(cpu_cs_n),
    .sync_out(w_cs_sync), .rise(w_unused_cs_rise), .fall(w_unused_cs_fall));
  spi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_we_sync (
    .clk(clk), .resetf(resetf), .async_in(cpu_we_n),
    .sync_out(w_unused_we_sync), .rise(w_unused_we_rise), .fall(w_we_fall));
  spi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .resetf(resetf), .async_in(cpu_rd_n),
    .sync_out(w_unused_rd_sync), .rise(w_rd_rise), .fall(w_rd_fall));

  assign w_unused_wdata = ^cpu_wdata[15:8];

  logic        w_wr_pulse, w_rd_pulse, w_ctrl_wr, w_tx_wr, w_rx_done, w_irq_mask;
  logic [15:0] w_ctrl_img, w_status, w_rd_mux;
  logic [15:0] r_cpu_rdata, r_data_in, r_rx_hold;
  logic [5:0]  r_ctrl_cfg;
  logic        r_en_req, r_tx_str, r_rx_str, r_rx_avail, r_rd_rx_pending;
  logic [3:0]  r_clean_cnt;
  en_state_t   r_state, w_next_state;

  // A write edge in the same cycle as a read edge suppresses the read
  assign w_wr_pulse = w_we_fall & ~w_cs_sync;
  assign w_rd_pulse = w_rd_fall & ~w_cs_sync & ~w_wr_pulse;
  assign w_ctrl_wr  = w_wr_pulse & (cpu_addr == ADDR_CTRL);
  assign w_tx_wr    = w_wr_pulse & (cpu_addr == ADDR_TXDATA);
  assign w_rx_done  = w_rd_rise & r_rd_rx_pending;

  assign w_ctrl_img = {7'd0, w_irq_mask, 1'b0, r_en_req, r_ctrl_cfg};
  assign w_status   = {6'd0, r_state, r_rx_avail, master_busy, rx_full_flag, rx_empty_flag,
                       rx_error, tx_full_flag, tx_empty_flag, tx_error};

  always_comb begin
    w_rd_mux = 16'd0;
    case (cpu_addr)
      ADDR_TXDATA: w_rd_mux = r_data_in;
      ADDR_RXDATA: w_rd_mux = r_rx_hold;
      ADDR_CTRL:   w_rd_mux = w_ctrl_img;
      ADDR_STATUS: w_rd_mux = w_status;
      default:     w_rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      r_cpu_rdata     <= 16'd0;
      r_data_in       <= 16'd0;
      r_rx_hold       <= 16'd0;
      r_ctrl_cfg      <= 6'd0;
      r_en_req        <= 1'b0;
      r_tx_str        <= 1'b0;
      r_rx_str        <= 1'b0;
      r_rx_avail      <= 1'b0;
      r_rd_rx_pending <= 1'b0;
      r_clean_cnt     <= 4'd0;
    end else begin
      r_tx_str <= w_tx_wr;
      r_rx_str <= w_rx_done;
      if (w_tx_wr) r_data_in <= cpu_wdata;
      if (w_ctrl_wr) begin
        r_ctrl_cfg <= cpu_wdata[5:0];
        r_en_req   <= cpu_wdata[CTRL_EN_BIT];
      end
      if (w_ctrl_wr && cpu_wdata[CTRL_CLR_BIT]) r_clean_cnt <= CLEAN_CYCLES[3:0];
      else if (r_clean_cnt != 4'd0)            r_clean_cnt <= r_clean_cnt - 4'd1;
      if (w_rd_pulse) begin
        r_cpu_rdata     <= w_rd_mux;
        r_rd_rx_pending <= (cpu_addr == ADDR_RXDATA);
      end else if (w_rd_rise) begin
        r_rd_rx_pending <= 1'b0;
      end
      // A fresh word arriving as the previous one is consumed stays available
      if (read_valid) begin
        r_rx_hold  <= dataOut;
        r_rx_avail <= 1'b1;
      end else if (w_rx_done) begin
        r_rx_avail <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) r_state <= EN_OFF;
    else         r_state <= w_next_state;
  end

  // Disabling while the master is busy parks in DRAIN until the transfer ends
  always_comb begin
    w_next_state = r_state;
    spi_enable   = 1'b0;
    case (r_state)
      EN_OFF: begin
        if (w_ctrl_wr && cpu_wdata[CTRL_EN_BIT]) w_next_state = EN_ON;
      end
      EN_ON: begin
        spi_enable = 1'b1;
        if (w_ctrl_wr && !cpu_wdata[CTRL_EN_BIT])
          w_next_state = master_busy ? EN_DRAIN : EN_OFF;
      end
      EN_DRAIN: begin
        spi_enable = 1'b1;
        if (w_ctrl_wr && cpu_wdata[CTRL_EN_BIT]) w_next_state = EN_ON;
        else if (!master_busy)                  w_next_state = EN_OFF;
      end
      default: w_next_state = EN_OFF;
    endcase
  end

`ifdef SPI_DSP_BUS_IRQ_EN
  logic r_irq_mask, r_irq_n;

  always_ff @(posedge clk or negedge resetf) begin
    if (!resetf) begin
      r_irq_mask <= 1'b0;
      r_irq_n    <= 1'b1;
    end else begin
      if (w_ctrl_wr) r_irq_mask <= cpu_wdata[CTRL_IRQ_BIT];
      r_irq_n <= ~(r_irq_mask & (r_rx_avail | tx_error | rx_error));
    end
  end

  assign w_irq_mask = r_irq_mask;
  assign cpu_irq_n  = r_irq_n;
`else
  assign w_irq_mask = 1'b0;
`endif

  assign cpu_rdata         = r_cpu_rdata;
  assign tx_str            = r_tx_str;
  assign rx_str            = r_rx_str;
  assign dataIn            = r_data_in;
  assign sclk_freq_divide  = r_ctrl_cfg[2:0];
  assign sclk_polarity     = r_ctrl_cfg[CTRL_POL_BIT];
  assign sdata_phase       = r_ctrl_cfg[CTRL_PHA_BIT];
  assign data_tx_direction = r_ctrl_cfg[CTRL_DIR_BIT];
  assign fifo_cleaning     = (r_clean_cnt != 4'd0);

endmodule

`default_nettype wire
